// File: rtl/adc_avg_filter_pkg.sv
// rtl/adc_avg_filter_pkg.sv - shared constants and FSM state type for the ADC averaging filter
// Purpose : system-wide ADC constants shared with the ADC interface block,
//           plus the averaging FSM state encoding.
// Contents: ADC_DATA_W, ADC_FRAME_LEN, FRAME_CNT_W, avg_state_t.
package adc_avg_filter_pkg;

  // Width of the parallel ADC sample word.
  localparam int ADC_DATA_W    = 12;
  // clk_50M cycles per ADC conversion frame.
  localparam int ADC_FRAME_LEN = 34;
  // Frame counter width; sized for the largest legal frame length (63).
  localparam int FRAME_CNT_W   = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

endpackage

// File: rtl/adc_avg_filter_if.sv
// rtl/adc_avg_filter_if.sv - sample/result bundle between the ADC side and the averaging filter
// Purpose : groups the filter's data, control and result signals.
// Ports   : data_in, enable, clear_minmax   (into the filter)
//           avg_out, avg_valid, min_out, max_out, sample_tick (out of the filter)
// Modports: slave  - the filter itself
//           master - whoever feeds samples and consumes results
interface adc_avg_filter_if
  import adc_avg_filter_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
);

  logic [DATA_W-1:0] data_in;
  logic              enable;
  logic              clear_minmax;
  logic [DATA_W-1:0] avg_out;
  logic              avg_valid;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] max_out;
  logic              sample_tick;

  modport slave (
    input  data_in,
    input  enable,
    input  clear_minmax,
    output avg_out,
    output avg_valid,
    output min_out,
    output max_out,
    output sample_tick
  );

  modport master (
    output data_in,
    output enable,
    output clear_minmax,
    input  avg_out,
    input  avg_valid,
    input  min_out,
    input  max_out,
    input  sample_tick
  );

endinterface

// File: rtl/adc_avg_filter_minmax_tracker.sv
// rtl/adc_avg_filter_minmax_tracker.sv - running min/max of captured raw ADC samples
// Purpose : compare-and-replace min/max registers, updated only on capture.
// Ports   : clk_50M, reset (async, active-high)
//           data_in  - raw sample word
//           capture  - sample is taken this edge
//           clear    - restart tracking
//           min_out / max_out - registered extremes
module adc_minmax_tracker
  import adc_avg_filter_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              capture,
  input  logic              clear,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
);

  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear && capture) begin
      // Restart tracking seeded with the sample being taken right now.
      min_d = data_in;
      max_d = data_in;
    end else if (clear) begin
      // Empty set: min at the top of the range, max at the bottom.
      min_d = '1;
      max_d = '0;
    end else if (capture) begin
      if (data_in < min_q) min_d = data_in;
      if (data_in > max_q) max_d = data_in;
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;

endmodule

// File: rtl/adc_avg_filter.sv
// rtl/adc_avg_filter.sv - boxcar average and min/max of the once-per-frame ADC sample
// Purpose : free-running frame counter picks one capture edge per conversion
//           frame; 2^LOG2_N captured samples are summed and averaged, with a
//           one-cycle avg_valid strobe; raw min/max tracked alongside.
// Ports   : clk_50M - 50 MHz system clock
//           reset   - asynchronous, active-high
//           bus     - adc_avg_filter_if.slave (data_in, enable, clear_minmax,
//                     avg_out, avg_valid, min_out, max_out, sample_tick)
module adc_avg_filter
  import adc_avg_filter_pkg::*;
#(
  parameter int DATA_W       = ADC_DATA_W,
  parameter int FRAME_LEN    = ADC_FRAME_LEN,
  parameter int SAMPLE_PHASE = 0,
  parameter int LOG2_N       = 3
) (
  input  logic           clk_50M,
  input  logic           reset,
  adc_avg_filter_if.slave bus
);

  localparam int ACC_W = DATA_W + LOG2_N;
  // n value on which the Nth sample arrives (2^LOG2_N - 1).
  localparam logic [LOG2_N-1:0] N_LAST = '1;

  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  avg_state_t             state_q;
  logic [ACC_W-1:0]       acc_q;
  logic [LOG2_N-1:0]      n_q;
  logic [DATA_W-1:0]      avg_q;
  logic                   avg_valid_q;
  logic                   sample_tick_q;

  logic                   capture;
  logic [ACC_W-1:0]       acc_sum;

  // Frame counter ignores enable so the capture phase stays locked to the
  // ADC conversion frame regardless of filter activity.
  always_comb begin
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    if (frame_cnt_q == FRAME_CNT_W'(FRAME_LEN - 1)) frame_cnt_d = '0;
  end

  assign capture = (frame_cnt_q == FRAME_CNT_W'(SAMPLE_PHASE)) && bus.enable;
  // ACC_W bits hold 2^LOG2_N full-scale samples, so this never wraps.
  assign acc_sum = acc_q + ACC_W'(bus.data_in);

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      sample_tick_q <= capture;
    end
  end

  // Averaging FSM with registered outputs.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      n_q         <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (!bus.enable) begin
        // Any enable drop throws away the partial sum.
        state_q <= IDLE;
        acc_q   <= '0;
        n_q     <= '0;
      end else if (capture) begin
        case (state_q)
          IDLE: begin
            state_q <= ACCUM;
            acc_q   <= ACC_W'(bus.data_in);
            n_q     <= LOG2_N'(1);
          end
          ACCUM: begin
            if (n_q == N_LAST) begin
              // Upper DATA_W bits of the sum are the truncated mean.
              avg_q       <= acc_sum[ACC_W-1:LOG2_N];
              avg_valid_q <= 1'b1;
              acc_q       <= '0;
              n_q         <= '0;
            end else begin
              acc_q <= acc_sum;
              n_q   <= n_q + LOG2_N'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            acc_q   <= '0;
            n_q     <= '0;
          end
        endcase
      end
    end
  end

  adc_minmax_tracker #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk_50M (clk_50M),
    .reset   (reset),
    .data_in (bus.data_in),
    .capture (capture),
    .clear   (bus.clear_minmax),
    .min_out (bus.min_out),
    .max_out (bus.max_out)
  );

  assign bus.avg_out     = avg_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.sample_tick = sample_tick_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb/tb_adc_avg_filter.sv - self-checking bench for adc_avg_filter
module tb_adc_avg_filter;
  import adc_avg_filter_pkg::*;

  localparam int DW  = 12;
  localparam int FL  = 34;
  localparam int SP  = 0;
  localparam int L2N = 3;
  localparam int N   = 1 << L2N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  adc_avg_filter_if #(.DATA_W(DW)) bus ();

  adc_avg_filter #(
    .DATA_W       (DW),
    .FRAME_LEN    (FL),
    .SAMPLE_PHASE (SP),
    .LOG2_N       (L2N)
  ) dut (
    .clk_50M (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a frame position, a queue of the samples kept since the
  // current run of enable began, and the published results.
  int          m_cnt;
  int          m_q[$];
  logic [11:0] m_avg, m_min, m_max;
  logic        m_valid, m_tick;
  int          valid_cnt;
  int          tick_no;
  int          first_valid;

  typedef struct {
    logic [11:0] data;
    logic        en;
    logic        clr;
    int          exp_valids;
    logic [11:0] exp_avg;
    logic [11:0] exp_min;
    logic [11:0] exp_max;
  } frame_vec_t;

  frame_vec_t tbl[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_q.delete();
    m_avg   = 12'h000;
    m_min   = 12'hFFF;
    m_max   = 12'h000;
    m_valid = 1'b0;
    m_tick  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".avg_out"},     32'(bus.avg_out),     32'(m_avg));
    chk({tag, ".avg_valid"},   32'(bus.avg_valid),   32'(m_valid));
    chk({tag, ".min_out"},     32'(bus.min_out),     32'(m_min));
    chk({tag, ".max_out"},     32'(bus.max_out),     32'(m_max));
    chk({tag, ".sample_tick"}, 32'(bus.sample_tick), 32'(m_tick));
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick(input string tag);
    logic cap;
    int   s;
    cap     = (m_cnt == SP) && bus.enable;
    m_valid = 1'b0;
    if (!bus.enable) begin
      m_q.delete();
    end else if (cap) begin
      m_q.push_back(int'(bus.data_in));
      if (m_q.size() == N) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_avg   = 12'(s / N);
        m_valid = 1'b1;
        m_q.delete();
      end
    end
    if (bus.clear_minmax && cap) begin
      m_min = bus.data_in;
      m_max = bus.data_in;
    end else if (bus.clear_minmax) begin
      m_min = 12'hFFF;
      m_max = 12'h000;
    end else if (cap) begin
      if (bus.data_in < m_min) m_min = bus.data_in;
      if (bus.data_in > m_max) m_max = bus.data_in;
    end
    m_tick = cap;
    m_cnt  = (m_cnt + 1) % FL;
    @(posedge clk);
    #1;
    if (bus.avg_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = tick_no;
    end
    tick_no++;
    check_all(tag);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.data_in = '0;
    bus.enable = 1'b0;
    bus.clear_minmax = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    tick_no = 0;
    first_valid = -1;
  endtask

  // One conversion frame; clr, if set, lands on the capture edge.
  task automatic run_frame(input logic [11:0] d, input logic en, input logic clr, input string tag);
    bus.data_in = d;
    bus.enable = en;
    bus.clear_minmax = clr;
    tick(tag);
    bus.clear_minmax = 1'b0;
    repeat (FL - 1) tick(tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{12'(i), 1'b1, 1'b0, (i == 7) ? 1 : 0, (i == 7) ? 12'h003 : 12'h000, 12'h000, 12'(i)};
    for (int i = 8; i < 16; i++)
      tbl[i] = '{12'hFFF, 1'b1, (i == 8), (i == 15) ? 1 : 0, (i == 15) ? 12'hFFF : 12'h003, 12'hFFF, 12'hFFF};
    tbl[16] = '{12'h123, 1'b1, 1'b1, 0, 12'hFFF, 12'h123, 12'h123};
    for (int i = 17; i < 21; i++)
      tbl[i] = '{12'h100, 1'b1, 1'b0, 0, 12'hFFF, 12'h100, 12'h123};
    tbl[21] = '{12'h300, 1'b0, 1'b0, 0, 12'hFFF, 12'h100, 12'h123};
    for (int i = 22; i < 30; i++)
      tbl[i] = '{12'h200, 1'b1, 1'b0, (i == 29) ? 1 : 0, (i == 29) ? 12'h200 : 12'hFFF, 12'h100, 12'h200};

    // Constant 0x800 from reset release: one strobe, right after edge 238.
    apply_reset();
    valid_cnt = 0;
    bus.data_in = 12'h800;
    bus.enable = 1'b1;
    repeat (8 * FL) tick("const800");
    chk("const800.first_valid_edge", 32'(first_valid), 32'd238);
    chk("const800.valid_count", 32'(valid_cnt), 32'd1);
    chk("const800.avg", 32'(bus.avg_out), 32'h800);

    // Frame-level vectors with hand-derived expectations.
    apply_reset();
    for (int f = 0; f < 30; f++) begin
      valid_cnt = 0;
      run_frame(tbl[f].data, tbl[f].en, tbl[f].clr, $sformatf("vec%0d", f));
      chk($sformatf("vec%0d.valids", f), 32'(valid_cnt), 32'(tbl[f].exp_valids));
      chk($sformatf("vec%0d.avg", f), 32'(bus.avg_out), 32'(tbl[f].exp_avg));
      chk($sformatf("vec%0d.min", f), 32'(bus.min_out), 32'(tbl[f].exp_min));
      chk($sformatf("vec%0d.max", f), 32'(bus.max_out), 32'(tbl[f].exp_max));
    end

    // clear_minmax on a non-capture edge empties the tracker.
    bus.data_in = 12'h555;
    bus.enable = 1'b1;
    repeat (5) tick("clr_nc");
    bus.clear_minmax = 1'b1;
    tick("clr_nc");
    bus.clear_minmax = 1'b0;
    chk("clr_nc.min", 32'(bus.min_out), 32'hFFF);
    chk("clr_nc.max", 32'(bus.max_out), 32'h000);
    repeat (FL - 6) tick("clr_nc");

    // Asynchronous reset with four samples accumulated.
    for (int f = 0; f < 3; f++) run_frame(12'hAAA, 1'b1, 1'b0, "pre_rst");
    #4;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.min", 32'(bus.min_out), 32'hFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_no = 0;
    first_valid = -1;
    valid_cnt = 0;
    for (int f = 0; f < 8; f++) run_frame(12'h040, 1'b1, 1'b0, "post_rst");
    chk("post_rst.avg", 32'(bus.avg_out), 32'h040);
    chk("post_rst.valid_count", 32'(valid_cnt), 32'd1);

    // Randomised frames: enable held per frame, data and clears per cycle.
    for (int f = 0; f < 60; f++) begin
      bus.enable = ($urandom_range(0, 99) < 85);
      for (int c = 0; c < FL; c++) begin
        bus.data_in = 12'($urandom);
        bus.clear_minmax = ($urandom_range(0, 99) < 3);
        if (bus.enable && $urandom_range(0, 499) == 0) bus.enable = 1'b0;
        tick("rand");
      end
      bus.clear_minmax = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
Downstream consumer of the 12-bit serial-ADC interface block's parallel sample word.
- Samples the ADC word once per conversion frame.
- Produces a boxcar average over 2^LOG2_N samples with a one-cycle valid strobe.
- Tracks running min/max of raw samples for the display/threshold logic.
- Runs on the same 50 MHz clock as the ADC interface; needs no handshake back to it.

Parameters:
DATA_W, 12, width of ADC sample and of avg/min/max outputs
FRAME_LEN, 34, clk_50M cycles per ADC conversion frame (range 2..63)
SAMPLE_PHASE, 0, frame_cnt value at which data_in is captured; integrator sets it to a phase where data_in is stable (range 0..FRAME_LEN-1)
LOG2_N, 3, log2 of samples per average (range 1..6)

Ports:
clk_50M  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_W  latest ADC sample word from the ADC interface
enable  in  1  level; high = capture and accumulate
clear_minmax  in  1  single-cycle pulse; restarts min/max tracking
avg_out  out  DATA_W  last completed average; held between updates
avg_valid  out  1  one-cycle pulse when avg_out updates
min_out  out  DATA_W  smallest raw sample since last clear/reset
max_out  out  DATA_W  largest raw sample since last clear/reset
sample_tick  out  1  registered; high in the cycle after each capture (debug/scope)

Behaviour:
- Reset values: frame_cnt=0, acc=0, n=0, avg_out=0, avg_valid=0, min_out=all-ones, max_out=0, sample_tick=0, state=IDLE.
- frame_cnt is free-running 0..FRAME_LEN-1 and wraps to 0. It ignores enable and is cleared only by reset.
- Capture condition: on a clock edge where frame_cnt==SAMPLE_PHASE and enable=1. The first capture is the first edge after reset release (with default SAMPLE_PHASE=0).
- Accumulator: width DATA_W+LOG2_N, unsigned, cannot overflow. n is LOG2_N bits and counts 0..2^LOG2_N-1.
- FSM states:
  - IDLE: acc=0, n=0. On capture, go to ACCUM with acc=data_in, n=1.
  - ACCUM: each capture adds data_in and increments n.
  - On the capture where n==2^LOG2_N-1 (the Nth sample): avg_out <= (acc+data_in)>>LOG2_N (truncating), avg_valid=1 next cycle, acc=0, n=0. Stay in ACCUM if enable remains high.
  - enable low in any cycle: go to IDLE and discard the partial sum (acc=0, n=0). avg_out keeps its last value and avg_valid is not asserted.
  - LOG2_N=1 degenerate case: every second capture completes an average.
- Latency: avg_valid and the new avg_out appear in the cycle after the Nth capture edge. avg_valid is exactly one cycle wide.
- Min/max: updated on every capture, compare-and-replace with unsigned compare; equal values leave the register unchanged.
- clear_minmax without a capture that cycle: min_out=all-ones, max_out=0.
- clear_minmax and a capture in the same cycle: min_out=max_out=data_in.
- Min/max tracking is independent of the averaging FSM and continues across enable toggles (capture still requires enable=1).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Nothing partial survives.
- data_in is treated as already synchronous to clk_50M; no resynchronisation.

Decomposition:
- Shared package: FSM state typedef (IDLE, ACCUM); ADC width constant DATA_W=12; FRAME_LEN=34 as the system conversion-frame constant, also used by the ADC interface.
- One natural sub-module: adc_minmax_tracker (data_in, capture, clear, min_out, max_out).
- The frame counter, accumulator and FSM stay in the top level.

Test Plan:
- Constant data_in=0x800, enable high from reset release, defaults: captures at edges 0,34,…,238; avg_valid pulses once in cycle 239; avg_out=0x800.
- Ramp data_in=0x000,0x001,…,0x007 (one value per frame): first avg_out=0x003, since 28>>3 truncates; min_out=0x000, max_out=0x007.
- All samples 0xFFF for 8 frames: avg_out=0xFFF with no overflow; max_out=0xFFF, min_out=0xFFF.
- enable dropped after 5 captures, then re-raised: no avg_valid; the next avg_valid comes 8 captures after re-enable; avg_out until then holds the prior value.
- clear_minmax pulsed on a capture edge with data_in=0x123: min_out=max_out=0x123. Pulsed on a non-capture edge: min_out=0xFFF, max_out=0x000.
- reset asserted mid-accumulation (n=4), then released: all outputs return to reset values at once; the first average after release uses only post-reset samples.
